// File: rtl/seg_scan_n.sv
// Multiplexed 7-segment scanner: one hex digit lit per DIV clocks, data snapshotted
// at each frame start, optional leading-zero blanking, registered dig/segment outputs.
module seg_scan_n #(
   parameter int NDIG = 4,
   parameter int DIV  = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [4*NDIG-1:0] data,
   input  logic [NDIG-1:0]   dp,
   input  logic              blank_lz,
   output logic [NDIG-1:0]   dig,
   output logic [7:0]        segments,
   output logic              frame
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     idx_next;
   logic              tick;
   logic              wrap;
   logic [4*NDIG-1:0] shadow_data;
   logic [4*NDIG-1:0] src_data;
   logic [NDIG-1:0]   shadow_dp;
   logic [NDIG-1:0]   src_dp;
   logic [NDIG-1:0]   zero_above;
   logic [NDIG-1:0]   dig_next;
   logic              lz_run;
   logic [3:0]        nibble;
   logic              blank_dig;
   logic [7:0]        seg_next;

   // Active-low g..a pattern for one hex nibble
   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      tick     = (cnt == CNT_MAX);
      wrap     = (idx == IDX_MAX);
      idx_next = wrap ? '0 : idx + 1'b1;
      // On a wrap the outputs must already show the values being captured
      src_data = wrap ? data : shadow_data;
      src_dp   = wrap ? dp : shadow_dp;

      lz_run     = 1'b1;
      zero_above = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         lz_run        = lz_run && (src_data[4*i +: 4] == 4'h0);
         zero_above[i] = lz_run;
      end

      dig_next = '1;
      for (int i = 0; i < NDIG; i++) begin
         dig_next[i] = (IW'(i) != idx_next);
      end

      nibble    = src_data[4*idx_next +: 4];
      blank_dig = blank_lz && (idx_next != '0) && zero_above[idx_next];
      seg_next  = {~src_dp[idx_next], blank_dig ? 7'h7F : hex_decode(nibble)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= IDX_MAX;
         shadow_data <= '0;
         shadow_dp   <= '0;
         dig         <= '1;
         segments    <= 8'hFF;
         frame       <= 1'b0;
      end else if (!en) begin
         cnt      <= '0;
         idx      <= IDX_MAX;
         dig      <= '1;
         segments <= 8'hFF;
         frame    <= 1'b0;
      end else begin
         frame <= 1'b0;
         cnt   <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            idx      <= idx_next;
            dig      <= dig_next;
            segments <= seg_next;
            if (wrap) begin
               shadow_data <= data;
               shadow_dp   <= dp;
               frame       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_n.sv
// Bench for seg_scan_n: NDIG=4/DIV=4 instance against a cycle-count reference model,
// plus an NDIG=1/DIV=1 instance checked directly.
module tb_seg_scan_n;

   localparam int NDIG = 4;
   localparam int DIV  = 4;

   localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   localparam logic [3:0] DIGS [4]     = '{4'hE, 4'hD, 4'hB, 4'h7};
   localparam logic [7:0] SCAN_SEG [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
   localparam logic [7:0] SNAP_SEG [6] = '{8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};
   localparam logic [7:0] BLK_SEG [8]  = '{8'hC0, 8'h92, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
   localparam logic [7:0] DP_SEG [4]   = '{8'h99, 8'hB0, 8'h24, 8'hF9};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  dig;
   logic [7:0]  segments;
   logic        frame;

   logic        en1 = 1'b0;
   logic        blz1 = 1'b0;
   logic [3:0]  data1 = '0;
   logic        dp1 = 1'b0;
   logic        dig1;
   logic [7:0]  seg1;
   logic        frame1;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   seg_scan_n #(.NDIG(NDIG), .DIV(DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .data(data), .dp(dp), .blank_lz(blank_lz),
      .dig(dig), .segments(segments), .frame(frame)
   );

   seg_scan_n #(.NDIG(1), .DIV(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .data(data1), .dp(dp1), .blank_lz(blz1),
      .dig(dig1), .segments(seg1), .frame(frame1)
   );

   // Reference model: digits are lit at enabled-cycle counts DIV, 2*DIV, ...
   int          m_cyc;
   logic [15:0] m_sd;
   logic [3:0]  m_sdp;
   logic [3:0]  m_dig;
   logic [7:0]  m_seg;
   logic        m_frame;

   function automatic int lit_digit(input int c);
      return (c / DIV - 1) % NDIG;
   endfunction

   function automatic logic [7:0] ref_seg(input logic [15:0] d, input logic [3:0] p,
                                          input logic blz, input int i);
      logic [15:0] upper;
      logic [7:0]  s;
      upper = d >> (4 * i);
      s = HEX[upper[3:0]];
      if (blz && i > 0 && upper == 16'h0) s = 8'hFF;
      s[7] = ~p[i];
      return s;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc <= 0; m_sd <= '0; m_sdp <= '0;
         m_dig <= 4'hF; m_seg <= 8'hFF; m_frame <= 1'b0;
      end else if (!en) begin
         m_cyc <= 0; m_dig <= 4'hF; m_seg <= 8'hFF; m_frame <= 1'b0;
      end else begin
         m_cyc   <= m_cyc + 1;
         m_frame <= 1'b0;
         if ((m_cyc + 1) % DIV == 0) begin
            m_dig <= 4'hF & ~(4'h1 << lit_digit(m_cyc + 1));
            if (lit_digit(m_cyc + 1) == 0) begin
               m_sd <= data; m_sdp <= dp; m_frame <= 1'b1;
               m_seg <= ref_seg(data, dp, blank_lz, 0);
            end else begin
               m_seg <= ref_seg(m_sd, m_sdp, blank_lz, lit_digit(m_cyc + 1));
            end
         end
      end
   end

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      total++;
      if ({dig, segments, frame} !== {4'hF, 8'hFF, 1'b0})
         $display("FAIL reset dig=%h seg=%h frame=%b expected F/FF/0", dig, segments, frame);
      else passed++;
      total++;
      if ({dig1, seg1, frame1} !== {1'b1, 8'hFF, 1'b0})
         $display("FAIL reset_n1 dig=%b seg=%h frame=%b expected 1/FF/0", dig1, seg1, frame1);
      else passed++;
   endtask

   task automatic test_scan();
      @(negedge clk);
      data = 16'h1234; dp = 4'h0; blank_lz = 1'b0; en = 1'b1; rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL scan_model cyc=%0d got %h/%h/%b expected %h/%h/%b",
                     i, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
         if (i % 4 == 0) begin
            total++;
            if (dig !== DIGS[(i/4-1)%4] || segments !== SCAN_SEG[(i/4-1)%4] ||
                frame !== ((i/4-1)%4 == 0))
               $display("FAIL scan_literal cyc=%0d got %h/%h/%b expected %h/%h/%b", i, dig,
                        segments, frame, DIGS[(i/4-1)%4], SCAN_SEG[(i/4-1)%4], ((i/4-1)%4 == 0));
            else passed++;
         end
      end
   endtask

   task automatic test_snapshot();
      for (int i = 1; i <= 28; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL snap_model cyc=%0d got %h/%h/%b expected %h/%h/%b",
                     m_cyc, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
         if (m_cyc % 4 == 0 && m_cyc >= 28) begin
            total++;
            if (dig !== DIGS[(m_cyc/4-1)%4] || segments !== SNAP_SEG[(m_cyc-28)/4])
               $display("FAIL snap_literal cyc=%0d got %h/%h expected %h/%h", m_cyc, dig,
                        segments, DIGS[(m_cyc/4-1)%4], SNAP_SEG[(m_cyc-28)/4]);
            else passed++;
         end
         if (i == 4) data = 16'hABCD;
      end
   endtask

   task automatic test_blanking();
      data = 16'h0050; blank_lz = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL blank_model cyc=%0d got %h/%h/%b expected %h/%h/%b",
                     m_cyc, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
         if (m_cyc % 4 == 0 && m_cyc >= 52) begin
            total++;
            if (dig !== DIGS[(m_cyc/4-1)%4] || segments !== BLK_SEG[(m_cyc-52)/4])
               $display("FAIL blank_literal cyc=%0d got %h/%h expected %h/%h", m_cyc, dig,
                        segments, DIGS[(m_cyc/4-1)%4], BLK_SEG[(m_cyc-52)/4]);
            else passed++;
         end
         if (i == 16) data = 16'h0000;
      end
   endtask

   task automatic test_dp();
      data = 16'h1234; dp = 4'b0100; blank_lz = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL dp_model cyc=%0d got %h/%h/%b expected %h/%h/%b",
                     m_cyc, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
         if (m_cyc % 4 == 0 && m_cyc >= 84) begin
            total++;
            if (dig !== DIGS[(m_cyc/4-1)%4] || segments !== DP_SEG[(m_cyc-84)/4])
               $display("FAIL dp_literal cyc=%0d got %h/%h expected %h/%h", m_cyc, dig,
                        segments, DIGS[(m_cyc/4-1)%4], DP_SEG[(m_cyc-84)/4]);
            else passed++;
         end
      end
   endtask

   task automatic test_enable();
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL en_model cyc=%0d got %h/%h/%b expected %h/%h/%b",
                     m_cyc, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
      end
      total++;
      if (dig !== 4'hB)
         $display("FAIL en_pre dig=%h expected b", dig);
      else passed++;
      en = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {4'hF, 8'hFF, 1'b0})
            $display("FAIL en_off step=%0d got %h/%h/%b expected F/FF/0", i, dig, segments, frame);
         else passed++;
      end
      en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL en_on_model step=%0d got %h/%h/%b expected %h/%h/%b",
                     i, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
      end
      total++;
      if ({dig, segments, frame} !== {4'hE, 8'h99, 1'b1})
         $display("FAIL en_reenable got %h/%h/%b expected E/99/1", dig, segments, frame);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL random_model step=%0d got %h/%h/%b expected %h/%h/%b",
                     i, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
         if ($urandom_range(5) == 0) begin
            data = 16'($urandom);
            if ($urandom_range(1) == 0) data = data >> (4 * $urandom_range(4));
         end
         if ($urandom_range(7) == 0) dp = 4'($urandom);
         if ($urandom_range(9) == 0) blank_lz = ~blank_lz;
         if (en && $urandom_range(39) == 0) en = 1'b0;
         else if (!en && $urandom_range(2) == 0) en = 1'b1;
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; data = 16'h00F0; blank_lz = 1'b1;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({dig, segments, frame} !== {4'hF, 8'hFF, 1'b0})
         $display("FAIL reset_mid got %h/%h/%b expected F/FF/0", dig, segments, frame);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         total++;
         if ({dig, segments, frame} !== {m_dig, m_seg, m_frame})
            $display("FAIL reset_mid_model step=%0d got %h/%h/%b expected %h/%h/%b",
                     i, dig, segments, frame, m_dig, m_seg, m_frame);
         else passed++;
         if (i == 4) begin
            total++;
            if ({dig, segments, frame} !== {4'hE, 8'hC0, 1'b1})
               $display("FAIL reset_mid_first got %h/%h/%b expected E/C0/1", dig, segments, frame);
            else passed++;
         end
      end
   endtask

   task automatic test_ndig1();
      logic [3:0] pdata;
      logic       pdp;
      @(negedge clk);
      en1 = 1'b1; blz1 = 1'b1; data1 = 4'h0; dp1 = 1'b0;
      for (int i = 0; i < 24; i++) begin
         pdata = data1; pdp = dp1;
         @(negedge clk);
         total++;
         if ({dig1, seg1, frame1} !== {1'b0, ~pdp, HEX[pdata][6:0], 1'b1})
            $display("FAIL n1_scan step=%0d got %b/%h/%b expected 0/%h/1",
                     i, dig1, seg1, frame1, {~pdp, HEX[pdata][6:0]});
         else passed++;
         data1 = 4'($urandom);
         dp1   = 1'($urandom);
      end
      en1 = 1'b0;
      @(negedge clk);
      total++;
      if ({dig1, seg1, frame1} !== {1'b1, 8'hFF, 1'b0})
         $display("FAIL n1_off got %b/%h/%b expected 1/FF/0", dig1, seg1, frame1);
      else passed++;
      en1 = 1'b1; data1 = 4'h7; dp1 = 1'b1;
      @(negedge clk);
      total++;
      if ({dig1, seg1, frame1} !== {1'b0, 8'h78, 1'b1})
         $display("FAIL n1_reenable got %b/%h/%b expected 0/78/1", dig1, seg1, frame1);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_snapshot();
      test_blanking();
      test_dp();
      test_enable();
      test_random();
      test_reset_mid();
      test_ndig1();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
